// File: rtl/up_down_count_sequencer.sv
// Host-facing sequencer for an external up/down counter: GOTO, shortest-path GOTO,
// bounded SWEEP between two bounds, and counter CLEAR, all over a valid/ready handshake.
module up_down_count_sequencer #(
   parameter int unsigned WIDTH  = 3,
   parameter int unsigned STEP_W = 8
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_a,
   input  logic [WIDTH-1:0]  cmd_b,
   input  logic [3:0]        cmd_passes,
   input  logic              abort,
   input  logic [WIDTH-1:0]  q,
   output logic              cnt_en,
   output logic              ud,
   output logic              cnt_clear_n,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] steps
);

   typedef enum logic [2:0] {StIdle, StMove, StSweep, StClr, StDone} state_e;

   localparam logic [1:0] OpGoto      = 2'b00;
   localparam logic [1:0] OpGotoShort = 2'b01;
   localparam logic [1:0] OpSweep     = 2'b10;
   localparam logic [1:0] OpClear     = 2'b11;

   state_e            state_q, state_d;
   logic              ud_q, ud_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [3:0]        passes_q, passes_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  target_q, target_d;
   logic              phase0_q, phase0_d;

   logic [WIDTH-1:0]  up_dist, dn_dist;
   logic              moving, at_target, sweep_trivial;

   // Modular distances; a tie resolves upward.
   assign up_dist       = cmd_a - q;
   assign dn_dist       = q - cmd_a;
   assign at_target     = (q == target_q);
   assign moving        = (state_q == StMove) || (state_q == StSweep);
   assign sweep_trivial = (passes_q == 4'd0) || (a_q >= b_q);

   assign cnt_en      = clear && moving && !at_target;
   assign cnt_clear_n = clear && (state_q != StClr);
   assign ud          = ud_q;
   assign busy        = (state_q != StIdle);
   assign cmd_ready   = (state_q == StIdle);
   assign done        = (state_q == StDone);
   assign steps       = steps_q;

   always_comb begin
      state_d  = state_q;
      ud_d     = ud_q;
      passes_d = passes_q;
      a_d      = a_q;
      b_d      = b_q;
      target_d = target_q;
      phase0_d = phase0_q;
      steps_d  = steps_q;
      if (cnt_en && (steps_q != '1)) begin
         steps_d = steps_q + STEP_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               a_d      = cmd_a;
               b_d      = cmd_b;
               passes_d = cmd_passes;
               target_d = cmd_a;
               phase0_d = 1'b1;
               steps_d  = '0;
               unique case (cmd_op)
                  OpGoto: begin
                     ud_d    = (cmd_a > q);
                     state_d = StMove;
                  end
                  OpGotoShort: begin
                     ud_d    = (up_dist <= dn_dist);
                     state_d = StMove;
                  end
                  OpSweep: begin
                     ud_d    = (cmd_a > q);
                     state_d = StSweep;
                  end
                  OpClear: begin
                     state_d = StClr;
                  end
               endcase
            end
         end
         StMove: begin
            if (abort) begin
               state_d = StIdle;
            end else if (at_target) begin
               state_d = StDone;
            end
         end
         StSweep: begin
            if (abort) begin
               state_d = StIdle;
            end else if (at_target) begin
               // Arrival: the new direction takes effect next cycle, giving one idle turnaround.
               if (phase0_q) begin
                  phase0_d = 1'b0;
                  if (sweep_trivial) begin
                     state_d = StDone;
                  end else begin
                     target_d = b_q;
                     ud_d     = 1'b1;
                  end
               end else begin
                  passes_d = passes_q - 4'd1;
                  if (passes_q == 4'd1) begin
                     state_d = StDone;
                  end else if (ud_q) begin
                     target_d = a_q;
                     ud_d     = 1'b0;
                  end else begin
                     target_d = b_q;
                     ud_d     = 1'b1;
                  end
               end
            end
         end
         StClr: begin
            state_d = abort ? StIdle : StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear) begin
         state_q  <= StIdle;
         ud_q     <= 1'b1;
         steps_q  <= '0;
         passes_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         target_q <= '0;
         phase0_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ud_q     <= ud_d;
         steps_q  <= steps_d;
         passes_q <= passes_d;
         a_q      <= a_d;
         b_q      <= b_d;
         target_q <= target_d;
         phase0_q <= phase0_d;
      end
   end

endmodule

// File: tb/tb_up_down_count_sequencer.sv
// Bench for up_down_count_sequencer: external counter model, per-cycle trace model built
// from command arithmetic on accept, and directed scenarios with literal end-state checks.
module tb_up_down_count_sequencer;

   localparam int unsigned WIDTH  = 3;
   localparam int unsigned STEP_W = 8;

   logic              clk = 1'b0;
   logic              clear = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = 2'b00;
   logic [WIDTH-1:0]  cmd_a = '0;
   logic [WIDTH-1:0]  cmd_b = '0;
   logic [3:0]        cmd_passes = '0;
   logic              abort = 1'b0;
   logic [WIDTH-1:0]  q;
   logic              cnt_en;
   logic              ud;
   logic              cnt_clear_n;
   logic              busy;
   logic              done;
   logic [STEP_W-1:0] steps;

   logic              load = 1'b0;
   logic [WIDTH-1:0]  load_val = '0;

   up_down_count_sequencer #(
      .WIDTH (WIDTH),
      .STEP_W(STEP_W)
   ) dut (
      .clk        (clk),
      .clear      (clear),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_passes (cmd_passes),
      .abort      (abort),
      .q          (q),
      .cnt_en     (cnt_en),
      .ud         (ud),
      .cnt_clear_n(cnt_clear_n),
      .busy       (busy),
      .done       (done),
      .steps      (steps)
   );

   initial forever #5 clk = ~clk;

   // External counter, with a bench-only preload used to set up start positions.
   always_ff @(posedge clk) begin
      if (!cnt_clear_n) q <= '0;
      else if (load) q <= load_val;
      else if (cnt_en) q <= ud ? q + WIDTH'(1) : q - WIDTH'(1);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected per-cycle trace while a command is in flight.
   typedef struct packed {
      logic             en;
      logic             ud;
      logic             clr_n;
      logic             dn;
      logic [WIDTH-1:0] q;
   } exp_t;

   exp_t plan[$];
   exp_t pe, ce;
   logic model_ok = 1'b0;
   logic exp_ud = 1'b1;
   int   exp_steps = 0;
   logic e_busy;
   int   en_cnt = 0, done_cnt = 0, clrlow_cnt = 0;

   task automatic add_leg(input logic [WIDTH-1:0] from, input logic [WIDTH-1:0] to,
                          input logic dir);
      logic [WIDTH-1:0] p;
      p = from;
      while (p != to) begin
         plan.push_back('{1'b1, dir, 1'b1, 1'b0, p});
         p = dir ? p + WIDTH'(1) : p - WIDTH'(1);
      end
      plan.push_back('{1'b0, dir, 1'b1, 1'b0, to});
   endtask

   task automatic build_plan(input logic [1:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [3:0] passes,
                             input logic [WIDTH-1:0] qv);
      logic             d, last;
      logic [WIDTH-1:0] up, dn, fq;
      up = a - qv;
      dn = qv - a;
      last = exp_ud;
      fq = a;
      case (op)
         2'b00: begin d = (a > qv); add_leg(qv, a, d); last = d; end
         2'b01: begin d = (up <= dn); add_leg(qv, a, d); last = d; end
         2'b10: begin
            d = (a > qv);
            add_leg(qv, a, d);
            last = d;
            if (passes != 0 && a < b) begin
               for (int i = 0; i < int'(passes); i++) begin
                  if (i % 2 == 0) begin add_leg(a, b, 1'b1); last = 1'b1; fq = b; end
                  else begin add_leg(b, a, 1'b0); last = 1'b0; fq = a; end
               end
            end
         end
         default: begin
            plan.push_back('{1'b0, exp_ud, 1'b0, 1'b0, qv});
            fq = '0;
         end
      endcase
      plan.push_back('{1'b0, last, 1'b1, 1'b1, fq});
   endtask

   // Model advance on each active edge.
   initial forever begin
      @(posedge clk);
      if (!clear) begin
         plan.delete();
         exp_ud = 1'b1;
         exp_steps = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         if (plan.size() == 0) begin
            if (cmd_valid) begin
               exp_steps = 0;
               build_plan(cmd_op, cmd_a, cmd_b, cmd_passes, q);
            end
         end else begin
            pe = plan.pop_front();
            if (pe.en && exp_steps != 255) exp_steps++;
            exp_ud = pe.ud;
            if (abort && !pe.dn) plan.delete();
         end
      end
   end

   // Compare process, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (model_ok) begin
         if (plan.size() != 0) begin
            ce = plan[0];
            e_busy = 1'b1;
         end else begin
            ce = '{1'b0, exp_ud, 1'b1, 1'b0, q};
            e_busy = 1'b0;
         end
         check("cmd_ready", cmd_ready, !e_busy);
         check("busy", busy, e_busy);
         check("done", done, ce.dn);
         check("cnt_en", cnt_en, clear ? ce.en : 1'b0);
         check("cnt_clear_n", cnt_clear_n, clear ? ce.clr_n : 1'b0);
         check("ud", ud, ce.ud);
         check("steps", steps, exp_steps);
         if (e_busy) check("q", q, ce.q);
         en_cnt += int'(cnt_en);
         done_cnt += int'(done);
         if (clear && !cnt_clear_n) clrlow_cnt++;
      end
   end

   task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [3:0] p, input logic ab);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_passes = p; abort = ab;
      @(posedge clk); #1;
      cmd_valid = 1'b0; abort = 1'b0;
   endtask

   task automatic preload(input logic [WIDTH-1:0] v);
      @(posedge clk); #1;
      load = 1'b1; load_val = v;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (!busy) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy=1 after 100 cycles, required 0", name);
   endtask

   int b_en, b_done, b_clr;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst ud", ud, 1);
      check("rst steps", steps, 0);
      check("rst busy", busy, 0);
      check("rst ready", cmd_ready, 1);
      check("rst done", done, 0);
      check("rst cnt_en", cnt_en, 0);
      check("rst clear_n", cnt_clear_n, 0);
      clear = 1'b1;

      b_en = en_cnt; b_done = done_cnt;
      issue(2'b00, 3'd5, 3'd0, 4'd0, 1'b0);
      wait_idle("goto5");
      check("goto5 q", q, 5);
      check("goto5 steps", steps, 5);
      check("goto5 en cycles", en_cnt - b_en, 5);
      check("goto5 done", done_cnt - b_done, 1);
      check("goto5 ready", cmd_ready, 1);
      check("goto5 ud", ud, 1);

      preload(3'd6);
      issue(2'b01, 3'd1, 3'd0, 4'd0, 1'b0);
      wait_idle("short61");
      check("short61 q", q, 1);
      check("short61 steps", steps, 3);
      check("short61 ud", ud, 1);

      preload(3'd6);
      issue(2'b01, 3'd2, 3'd0, 4'd0, 1'b0);
      wait_idle("short62");
      check("short62 q", q, 2);
      check("short62 steps", steps, 4);
      check("short62 ud", ud, 1);

      preload(3'd0);
      b_done = done_cnt;
      issue(2'b10, 3'd2, 3'd4, 4'd3, 1'b0);
      wait_idle("sweep243");
      check("sweep243 q", q, 4);
      check("sweep243 steps", steps, 8);
      check("sweep243 done", done_cnt - b_done, 1);

      preload(3'd7);
      issue(2'b10, 3'd5, 3'd3, 4'd2, 1'b0);
      wait_idle("sweep532");
      check("sweep532 q", q, 5);
      check("sweep532 steps", steps, 2);
      check("sweep532 ud", ud, 0);

      preload(3'd6);
      b_done = done_cnt; b_clr = clrlow_cnt;
      issue(2'b11, 3'd0, 3'd0, 4'd0, 1'b0);
      wait_idle("clear");
      check("clear q", q, 0);
      check("clear steps", steps, 0);
      check("clear low cycles", clrlow_cnt - b_clr, 1);
      check("clear done", done_cnt - b_done, 1);

      preload(3'd0);
      b_done = done_cnt;
      issue(2'b00, 3'd7, 3'd0, 4'd0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort busy", busy, 0);
      check("abort q", q, 3);
      check("abort steps", steps, 3);
      check("abort cnt_en", cnt_en, 0);
      check("abort done", done_cnt - b_done, 0);

      issue(2'b00, 3'd0, 3'd0, 4'd0, 1'b1);
      wait_idle("abort+goto0");
      check("abortcmd q", q, 0);
      check("abortcmd steps", steps, 3);
      check("abortcmd done", done_cnt - b_done, 1);
      check("abortcmd ud", ud, 0);

      // Reset lands mid-traversal while moving down (ud=0) so ud=1 after reset is observable.
      preload(3'd0);
      b_done = done_cnt;
      issue(2'b10, 3'd2, 3'd4, 4'd3, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      check("pre-rst ud", ud, 0);
      clear = 1'b0;
      @(negedge clk); #1;
      check("midrst cnt_en", cnt_en, 0);
      check("midrst clear_n", cnt_clear_n, 0);
      @(posedge clk); #1;
      check("midrst busy", busy, 0);
      check("midrst ud", ud, 1);
      check("midrst steps", steps, 0);
      @(posedge clk); #1;
      clear = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst done", done_cnt - b_done, 0);
      check("midrst q", q, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/up_down_count_sequencer.md
Name: up_down_count_sequencer

Overview:
- Controller that sequences an external WIDTH-bit synchronous up/down counter.
- Drives the counter's enable, direction and clear; observes its q.
- Accepts commands from a host over a valid/ready handshake: go-to-target (direct or shortest wrap path), bounded sweep between two bounds, or counter clear.
- Sits between host logic and the counter so the host never toggles ud/clear directly.

Parameters:
- WIDTH, 3, bit width of counter value, targets and bounds.
- STEP_W, 8, width of the saturating step counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- clear  input  1  synchronous active-low reset.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready at a clk edge.
- cmd_op  input  2  00 GOTO, 01 GOTO_SHORT, 10 SWEEP, 11 CLEAR.
- cmd_a  input  WIDTH  target (GOTO/GOTO_SHORT) or low bound (SWEEP).
- cmd_b  input  WIDTH  high bound (SWEEP); ignored otherwise.
- cmd_passes  input  4  SWEEP traversal count.
- abort  input  1  synchronous abort; stops motion, returns to IDLE.
- q  input  WIDTH  present value of the external counter.
- cnt_en  output  1  counter steps at next edge when high.
- ud  output  1  direction: 1 up, 0 down (registered).
- cnt_clear_n  output  1  active-low clear to counter.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on command completion, not on abort.
- steps  output  STEP_W  cnt_en-high cycles for current or last command, saturates at all-ones.

Behaviour:
- Reset (clear=0 at edge):
  - state=IDLE, ud=1, done=0, steps=0, internal pass count=0.
  - cnt_en=0 and cnt_clear_n=0 combinationally while clear=0.
- States: IDLE, MOVE, SWEEP, CLR, DONE.
- cnt_en = (state is MOVE or SWEEP) && q != current target. Compared combinationally, so there is never an overshoot. The counter's new value is visible on q one cycle after an enabled edge.
- On accept, latch cmd_a, cmd_b and cmd_passes, and reset steps to 0.
- GOTO:
  - ud latched as (cmd_a > q), unsigned compare; no wrap.
  - Go to MOVE with target=cmd_a.
  - If q == target in MOVE, go to DONE. If q already equals target at accept, MOVE lasts one cycle with cnt_en=0.
- GOTO_SHORT:
  - up_dist = (cmd_a - q) mod 2^WIDTH; dn_dist = (q - cmd_a) mod 2^WIDTH.
  - ud latched = (up_dist <= dn_dist), so a tie goes up. The path may wrap through 0 or all-ones.
  - Then identical to GOTO.
- SWEEP:
  - Phase 0: move to cmd_a, direct direction as GOTO.
  - Each traversal: target toggles between cmd_b (ud=1) and cmd_a (ud=0); each arrival decrements the pass count.
  - Go to DONE when the pass count reaches 0 on arrival.
  - If cmd_passes=0, or cmd_a >= cmd_b, complete after phase 0.
  - Direction reversal is registered: the arrival cycle has cnt_en=0, and the next cycle steps with the new ud. One idle cycle per turnaround.
- CLR:
  - cnt_clear_n=0 for exactly one cycle, then DONE. steps stays 0.
- DONE: done=1 for one cycle, then IDLE. cmd_ready=0 in DONE.
- abort:
  - Sampled every edge, highest priority after clear.
  - From MOVE, SWEEP or CLR: go to IDLE next edge with cnt_en low from that edge; no done pulse; steps holds.
  - In IDLE or DONE, abort has no effect (DONE still pulses).
  - abort and cmd_valid high together in IDLE: the command is accepted and abort is ignored.
- steps increments on every edge where cnt_en=1, saturating at 2^STEP_W-1.
- ud holds its last value in IDLE.
- Reset mid-command: immediate IDLE, no done pulse.

Test Plan:
- Reset, then GOTO a=5 from q=0 -> ud=1, cnt_en high 5 cycles, q=5, done pulse, steps=5, cmd_ready high the cycle after DONE.
- GOTO_SHORT a=1 from q=6 (WIDTH=3) -> ud=1, path 6,7,0,1, steps=3. GOTO_SHORT a=2 from q=6 -> tie (4 vs 4) -> ud=1, steps=4.
- SWEEP a=2 b=4 passes=3 from q=0 -> q path 0,1,2,3,4,3,2,3,4 with one enable-low cycle at each turnaround, done after final arrival at 4, steps=8.
- SWEEP a=5 b=3 passes=2 from q=7 -> moves down to 5, done, steps=2. CLEAR from q=6 -> cnt_clear_n low exactly 1 cycle, done next cycle, steps=0.
- GOTO a=7 from q=0, abort after 3 steps -> cnt_en low at next edge, q=3, no done, steps=3, busy=0. Then abort+cmd_valid (GOTO a=0) in IDLE -> command accepted.
- clear driven low mid-SWEEP -> busy=0, cnt_en=0, cnt_clear_n=0 during reset, ud=1, steps=0, no done pulse.
